// File: rtl/mac_pkg.sv
// Shared constants and helpers for the vector multiply-accumulate block.
package mac_pkg;

  localparam int unsigned DW_DEF     = 8;
  localparam int unsigned LANES_DEF  = 4;
  localparam int unsigned AW_DEF     = 24;
  localparam int unsigned PIPE_DEPTH = 4;

  // Width of the signed sum of LANES full-precision DW x DW products.
  function automatic int unsigned sum_width(input int unsigned dw, input int unsigned lanes);
    return 2 * dw + $clog2(lanes);
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One registered signed DW x DW multiplier lane.
module mac_lane
  import mac_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic signed [2*DW-1:0] p
);

  // Full-precision product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p <= '0;
    else        p <= (2*DW)'(a) * (2*DW)'(b);
  end

endmodule

// File: rtl/mac_vec_acc.sv
// Pipelined LANES-wide dot-product accumulator.
// S1 input register, S2 lane products, S3 lane sum, S4 accumulator/result.
// Optional build macro MAC_VEC_ACC_SAT_EN: saturating accumulate with a
// sticky per-packet overflow flag; otherwise the accumulator wraps.
module mac_vec_acc
  import mac_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned LANES = LANES_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    w_load,
  input  logic [LANES*DW-1:0]     w_in,
  input  logic                    x_valid,
  input  logic [LANES*DW-1:0]     x_in,
  input  logic                    x_last,
  input  logic                    clr,
  output logic signed [AW-1:0]    acc_out,
  output logic                    acc_valid,
  output logic                    ovf,
  output logic                    busy
);

  localparam int unsigned VW = LANES * DW;
  localparam int unsigned PW = 2 * DW;
  localparam int unsigned SW = sum_width(DW, LANES);

  logic [VW-1:0]        w_reg;
  logic [VW-1:0]        s1_x, s1_w;
  logic                 s1_valid, s1_last;
  logic [LANES*PW-1:0]  s2_p;
  logic                 s2_valid, s2_last;
  logic signed [SW-1:0] lane_sum, s3_sum;
  logic                 s3_valid, s3_last;
  logic signed [AW-1:0] acc, acc_nxt;
  logic signed [AW:0]   acc_base, acc_wide;
  logic                 open_pkt;
  logic                 busy_nxt;

  // Weight register; a beat in the same cycle snapshots the old value in S1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      w_reg <= '0;
    else if (w_load) w_reg <= w_in;
  end

  // S1: capture the beat together with the weights it must use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_x     <= '0;
      s1_w     <= '0;
    end else begin
      s1_valid <= x_valid & ~clr;
      if (x_valid) begin
        s1_x    <= x_in;
        s1_w    <= w_reg;
        s1_last <= x_last;
      end
    end
  end

  // S2: one registered multiplier per lane.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_lane #(.DW(DW)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (s1_x[g*DW +: DW]),
      .b     (s1_w[g*DW +: DW]),
      .p     (s2_p[g*PW +: PW])
    );
  end

  // S2 control bits travel alongside the lane products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
    end else begin
      s2_valid <= s1_valid & ~clr;
      s2_last  <= s1_last;
    end
  end

  // Adder tree over sign-extended lane products.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + SW'($signed(s2_p[i*PW +: PW]));
    end
  end

  // S3: registered lane sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_last  <= 1'b0;
      s3_sum   <= '0;
    end else begin
      s3_valid <= s2_valid & ~clr;
      s3_last  <= s2_last;
      s3_sum   <= lane_sum;
    end
  end

`ifdef MAC_VEC_ACC_SAT_EN
  logic sticky, sticky_nxt, clamp;
`endif

  // Next accumulator value: restart on packet open, optional clamp.
  always_comb begin
    acc_base = open_pkt ? (AW+1)'(acc) : '0;
    acc_wide = acc_base + (AW+1)'(s3_sum);
    acc_nxt  = acc_wide[AW-1:0];
`ifdef MAC_VEC_ACC_SAT_EN
    clamp = acc_wide[AW] != acc_wide[AW-1];
    if (clamp) acc_nxt = {acc_wide[AW], {(AW-1){~acc_wide[AW]}}};
    sticky_nxt = (open_pkt & sticky) | clamp;
`endif
  end

  // S4: accumulator, packet-open flag and result strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      open_pkt  <= 1'b0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
    end else if (clr) begin
      acc       <= '0;
      open_pkt  <= 1'b0;
      acc_valid <= 1'b0;
    end else begin
      acc_valid <= s3_valid & s3_last;
      if (s3_valid) begin
        acc      <= acc_nxt;
        open_pkt <= ~s3_last;
        if (s3_last) acc_out <= acc_nxt;
      end
    end
  end

`ifdef MAC_VEC_ACC_SAT_EN
  // Sticky per-packet clamp flag, published with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= 1'b0;
      ovf    <= 1'b0;
    end else if (clr) begin
      sticky <= 1'b0;
    end else if (s3_valid) begin
      sticky <= sticky_nxt;
      if (s3_last) ovf <= sticky_nxt;
    end
  end
`else
  assign ovf = 1'b0;
`endif

  // Registered busy: next-cycle view of the stage valids and open packet.
  always_comb begin
    busy_nxt = ~clr & (x_valid | s1_valid | s2_valid |
                       (s3_valid ? ~s3_last : open_pkt));
  end

  // Busy flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= 1'b0;
    else        busy <= busy_nxt;
  end

endmodule

// File: tb/tb_mac_vec_acc.sv
// Testbench for mac_vec_acc (defaults LANES=4, DW=8, AW=24).
// Honours MAC_VEC_ACC_SAT_EN for the reference model.
module tb_mac_vec_acc;

  localparam int unsigned DW    = 8;
  localparam int unsigned LANES = 4;
  localparam int unsigned AW    = 24;
  localparam longint      AMAX  = (longint'(1) << (AW-1)) - 1;
  localparam longint      AMIN  = -(longint'(1) << (AW-1));

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 w_load;
  logic [LANES*DW-1:0]  w_in;
  logic                 x_valid;
  logic [LANES*DW-1:0]  x_in;
  logic                 x_last;
  logic                 clr;
  logic signed [AW-1:0] acc_out;
  logic                 acc_valid;
  logic                 ovf;
  logic                 busy;

  mac_vec_acc #(.DW(DW), .LANES(LANES), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .w_load    (w_load),
    .w_in      (w_in),
    .x_valid   (x_valid),
    .x_in      (x_in),
    .x_last    (x_last),
    .clr       (clr),
    .acc_out   (acc_out),
    .acc_valid (acc_valid),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: whole-beat dot products, packet sums, results queued
  // with the cycle they must appear on.
  typedef struct {
    int     due;
    longint val;
    bit     ov;
  } exp_t;

  exp_t                q[$];
  int                  edge_n  = 0;
  longint              m_acc   = 0;
  bit                  m_open  = 0;
  bit                  m_stk   = 0;
  logic [LANES*DW-1:0] m_w     = '0;

  function automatic longint wrap_aw(input longint v);
    logic [AW-1:0] t;
    t = v[AW-1:0];
    return longint'($signed(t));
  endfunction

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Model update on every rising edge using the inputs the DUT samples.
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (!rst_n) begin
        q.delete();
        m_acc = 0; m_open = 0; m_stk = 0; m_w = '0;
      end else begin
        if (clr) begin
          while (q.size() > 0 && q[q.size()-1].due >= edge_n) void'(q.pop_back());
          m_acc = 0; m_open = 0; m_stk = 0;
        end else if (x_valid) begin
          longint dot;
          dot = 0;
          for (int i = 0; i < LANES; i++) begin
            logic signed [DW-1:0] xa, wa;
            xa = x_in[i*DW +: DW];
            wa = m_w[i*DW +: DW];
            dot += longint'(xa) * longint'(wa);
          end
          if (!m_open) begin m_acc = 0; m_stk = 0; end
          m_acc += dot;
`ifdef MAC_VEC_ACC_SAT_EN
          if (m_acc > AMAX) begin m_acc = AMAX; m_stk = 1; end
          else if (m_acc < AMIN) begin m_acc = AMIN; m_stk = 1; end
`else
          m_acc = wrap_aw(m_acc);
`endif
          m_open = !x_last;
          if (x_last) q.push_back('{due: edge_n + 3, val: m_acc, ov: m_stk});
        end
        if (w_load) m_w = w_in;
      end
    end
  end

  // Result checker, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0 && q[0].due == edge_n) begin
        chk("acc_valid", longint'(acc_valid), 1);
        chk("acc_out", longint'(acc_out), q[0].val);
        chk("ovf", longint'(ovf), longint'(q[0].ov));
        void'(q.pop_front());
      end else if (acc_valid) begin
        chk("spurious_acc_valid", 1, 0);
      end
    end
  end

  task automatic drv(input logic v, input logic [31:0] x, input logic l,
                     input logic wl, input logic [31:0] w, input logic c);
    @(negedge clk);
    x_valid = v; x_in = x; x_last = l; w_load = wl; w_in = w; clr = c;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  longint exp_big, exp_big_ovf, held;
  logic [31:0] ones;

  initial begin
    ones = pack4(1, 1, 1, 1);
    rst_n = 1'b0; w_load = 1'b0; w_in = '0; x_valid = 1'b0;
    x_in = '0; x_last = 1'b0; clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_acc_out", longint'(acc_out), 0);
    chk("rst_acc_valid", longint'(acc_valid), 0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_busy", longint'(busy), 0);

    // Single-beat packet.
    drv(1'b0, '0, 1'b0, 1'b1, ones, 1'b0);
    drv(1'b1, pack4(1, 2, 3, 4), 1'b1, 1'b0, '0, 1'b0);
    idle(1);
    chk("busy_after_beat", longint'(busy), 1);
    idle(6);
    chk("t1_acc", longint'(acc_out), 10);
    chk("t1_idle_busy", longint'(busy), 0);

    // Three beats with idle gaps.
    drv(1'b0, '0, 1'b0, 1'b1, pack4(2, -1, 0, 3), 1'b0);
    drv(1'b1, ones, 1'b0, 1'b0, '0, 1'b0);
    idle(1);
    drv(1'b1, ones, 1'b0, 1'b0, '0, 1'b0);
    idle(2);
    drv(1'b1, ones, 1'b1, 1'b0, '0, 1'b0);
    idle(7);
    chk("t2_acc", longint'(acc_out), 12);

    // Long packet of extreme values.
    drv(1'b0, '0, 1'b0, 1'b1, pack4(-128, -128, -128, -128), 1'b0);
    for (int i = 0; i < 512; i++)
      drv(1'b1, pack4(-128, -128, -128, -128), 1'(i == 511), 1'b0, '0, 1'b0);
    idle(7);
`ifdef MAC_VEC_ACC_SAT_EN
    exp_big = 8388607; exp_big_ovf = 1;
`else
    exp_big = 0; exp_big_ovf = 0;
`endif
    chk("t3_acc", longint'(acc_out), exp_big);
    chk("t3_ovf", longint'(ovf), exp_big_ovf);

    // clr mid-packet, beat in the clr cycle is discarded.
    drv(1'b0, '0, 1'b0, 1'b1, ones, 1'b0);
    drv(1'b1, ones, 1'b0, 1'b0, '0, 1'b0);
    drv(1'b1, ones, 1'b0, 1'b0, '0, 1'b0);
    drv(1'b1, ones, 1'b1, 1'b0, '0, 1'b1);
    idle(6);
    chk("t4_acc_held", longint'(acc_out), exp_big);
    chk("t4_busy", longint'(busy), 0);
    drv(1'b1, ones, 1'b1, 1'b0, '0, 1'b0);
    idle(7);
    chk("t4_acc", longint'(acc_out), 4);

    // Weight load coinciding with a beat.
    drv(1'b1, pack4(1, 0, 0, 0), 1'b1, 1'b1, pack4(5, 5, 5, 5), 1'b0);
    idle(7);
    chk("t5_old_w", longint'(acc_out), 1);
    drv(1'b1, ones, 1'b1, 1'b0, '0, 1'b0);
    idle(7);
    chk("t5_new_w", longint'(acc_out), 20);

    // Reset while a packet is open.
    drv(1'b1, ones, 1'b0, 1'b0, '0, 1'b0);
    drv(1'b1, ones, 1'b0, 1'b0, '0, 1'b0);
    idle(5);
    chk("t6_busy_open", longint'(busy), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_acc_out", longint'(acc_out), 0);
    chk("t6_acc_valid", longint'(acc_valid), 0);
    chk("t6_ovf", longint'(ovf), 0);
    chk("t6_busy", longint'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    drv(1'b0, '0, 1'b0, 1'b1, pack4(1, 2, 3, 4), 1'b0);
    drv(1'b1, ones, 1'b0, 1'b0, '0, 1'b0);
    drv(1'b1, pack4(1, 1, 1, -1), 1'b1, 1'b0, '0, 1'b0);
    idle(7);
    chk("t6_after_rst", longint'(acc_out), 12);

    // Randomized traffic against the model.
    held = 0;
    for (int i = 0; i < 400; i++) begin
      drv(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 9) == 0), $urandom, 1'($urandom_range(0, 49) == 0));
    end
    idle(10);
    chk("drain_pending", longint'(q.size()), held);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mac_vec_acc.md
MAC_VEC_ACC -- requirements
Module: mac_vec_acc

Interface
REQ-001 The block SHALL take parameter DW, default 8, as the signed width of each activation and weight element.
REQ-002 The block SHALL take parameter LANES, default 4, as the number of parallel multiply lanes.
REQ-003 The block SHALL take parameter AW, default 24, as the signed accumulator and result width.
REQ-004 Port clk, input, 1, clock; all state SHALL be on its rising edge.
REQ-005 Port rst_n, input, 1, reset; it SHALL be asynchronous and active-low.
REQ-006 Port w_load, input, 1, loads w_in into the weight register.
REQ-007 Port w_in, input, LANES*DW, packed signed weights; lane i SHALL occupy bits [i*DW +: DW].
REQ-008 Port x_valid, input, 1, qualifies x_in and x_last.
REQ-009 Port x_in, input, LANES*DW, packed signed activations, laid out as w_in.
REQ-010 Port x_last, input, 1, marks the final beat of a dot-product packet.
REQ-011 Port clr, input, 1, synchronous flush of the pipeline and the accumulator.
REQ-012 Port acc_out, output, AW, signed packet result.
REQ-013 Port acc_valid, output, 1, one-cycle strobe for acc_out.
REQ-014 Port ovf, output, 1, packet-overflow flag, valid with acc_valid.
REQ-015 Port busy, output, 1, high while any pipeline stage is valid or a packet is open.

Function
REQ-016 The weight register SHALL update on w_load; a beat accepted in the same cycle SHALL use the previous weights.
REQ-017 Pipeline: S1 SHALL register x_in, x_valid and x_last.
REQ-018 S2 SHALL register the LANES signed products, each 2*DW bits, computed from S1 data and the weight register.
REQ-019 S3 SHALL register the lane sum, sign-extended to 2*DW+clog2(LANES) bits.
REQ-020 S4 SHALL hold the accumulator.
REQ-021 The first valid beat of a packet SHALL load acc = S3 sum; each later beat SHALL set acc = acc + S3 sum.
REQ-022 Cycles with x_valid low SHALL hold all accumulator state; gaps inside a packet SHALL be allowed.
REQ-023 A beat with x_valid and x_last accepted at cycle t SHALL produce acc_valid at t+4 for exactly one cycle.
REQ-024 acc_out SHALL hold its value until the next acc_valid.
REQ-025 The beat after a last beat SHALL open a new packet; a one-beat packet (x_last on the first beat) SHALL be legal.
REQ-026 clr SHALL clear the S1–S3 valid bits, the accumulator, the open-packet flag and the overflow flag.
REQ-027 A beat presented in the same cycle as clr SHALL be discarded.
REQ-028 clr SHALL NOT modify the weights or acc_out.
REQ-029 busy SHALL be high while any S1–S3 valid bit is set or a packet is open.

Reset
REQ-030 rst_n low SHALL clear the weights, all pipeline registers, the accumulator, acc_out, acc_valid, ovf and busy to 0.
REQ-031 Reset mid-packet SHALL discard that packet, and no acc_valid SHALL follow for it.

Configuration
REQ-032 With MAC_VEC_ACC_SAT_EN defined, each accumulate SHALL clamp to [-2^(AW-1), 2^(AW-1)-1].
REQ-033 With MAC_VEC_ACC_SAT_EN defined, any clamp SHALL set a sticky packet flag, output as ovf with acc_valid and cleared at the next packet start.
REQ-034 Without MAC_VEC_ACC_SAT_EN, the accumulator SHALL wrap modulo 2^AW and ovf SHALL be tied 0.

Structure
REQ-035 Shared package mac_pkg SHALL hold the default DW/LANES/AW constants, the pipeline depth constant (4) and the helper function for the lane-sum width.
REQ-036 One sub-module, mac_lane (registered signed DW x DW multiply), SHALL be instantiated LANES times.
REQ-037 The adder tree and the accumulator SHALL reside in mac_vec_acc.

Verification (LANES=4, DW=8, AW=24)
REQ-038 w={1,1,1,1}; one beat x={1,2,3,4} with x_last -> acc_out=10 and acc_valid at t+4.
REQ-039 w={2,-1,0,3}; three beats of x={1,1,1,1} with idle gaps, last on beat 3 -> acc_out=12 and a single acc_valid.
REQ-040 All weights and activations = -128, 512 beats -> SAT_EN: acc_out=8388607 and ovf=1; no macro: acc_out=0 and ovf=0.
REQ-041 clr after beat 2 of a packet, then a new one-beat packet {1,1,1,1}·{1,1,1,1} -> acc_out=4 and no stale result.
REQ-042 w_load of {5,5,5,5} in the same cycle as a beat {1,0,0,0} with old w={1,1,1,1}, last -> acc_out=1; the next packet uses weight 5.
REQ-043 rst_n pulse mid-packet -> all outputs 0, no acc_valid, and the next packet result is correct.
